// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t  - FSM encoding (IDLE waits for a frame start, XFER owns the FIFO)
//   gid_width()  - width of a source index, never less than one bit
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_arb_if: frame-source bus plus FIFO write port around the arbiter.
//   s_valid/s_data/s_last/s_ready - NUM_SRC valid/ready beat sources,
//                                   source i data at [i*WIDTH +: WIDTH]
//   fifo_wr_en/fifo_wdata         - write strobe and {last, data} word
//   fifo_full/fifo_almost_full    - FIFO status
// Modports: master = sources and FIFO side, slave = the arbiter.
interface fifo_arb_if #(
    parameter int NUM_SRC = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_SRC-1:0]       s_valid;
    logic [NUM_SRC*WIDTH-1:0] s_data;
    logic [NUM_SRC-1:0]       s_last;
    logic [NUM_SRC-1:0]       s_ready;
    logic                     fifo_wr_en;
    logic [WIDTH:0]           fifo_wdata;
    logic                     fifo_full;
    logic                     fifo_almost_full;

    modport master (
        output s_valid, s_data, s_last, fifo_full, fifo_almost_full,
        input  s_ready, fifo_wr_en, fifo_wdata
    );

    modport slave (
        input  s_valid, s_data, s_last, fifo_full, fifo_almost_full,
        output s_ready, fifo_wr_en, fifo_wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req - request vector (N bits)
//   ptr - highest-priority index this round
//   any - at least one request present
//   idx - first set request at or above ptr, wrapping past N-1 to 0
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = gid_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);
    int c;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = PW'(c);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, frame-granular arbiter for the write port of
// one sync FIFO. A grant is held from the first beat to the s_last beat, so
// frames never interleave; each beat is written as {last, data}.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - fifo_arb_if.slave (sources and FIFO write port)
//   grant_id   - current owner
//   busy       - 1 while a frame is being transferred
//   frame_cnt  - completed frames per source, source i at [i*CNT_W +: CNT_W]
//                (only when FIFO_ARB_STATS_EN is defined)
// Build option: `define FIFO_ARB_STATS_EN adds the frame_cnt port/counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int WIDTH   = 32,
    parameter  int CNT_W   = 16,
    localparam int GID_W   = gid_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_arb_if.slave          bus,
    output logic [GID_W-1:0]   grant_id,
    output logic               busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_SRC*CNT_W-1:0] frame_cnt
`endif
);
    arb_state_t         state, state_nxt;
    logic [GID_W-1:0]   rr_ptr, rr_ptr_nxt, gid_nxt;
    logic               pick_any;
    logic [GID_W-1:0]   pick_idx;
    logic [NUM_SRC-1:0] s_ready;
    logic               wr_en;
    logic [WIDTH-1:0]   src_data [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign src_data[gi] = bus.s_data[gi*WIDTH +: WIDTH];
    end

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req (bus.s_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= gid_nxt;
        end
    end

    // almost_full only blocks a new frame; inside a frame only full stalls.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gid_nxt    = grant_id;
        s_ready    = '0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && !bus.fifo_almost_full) begin
                    state_nxt = XFER;
                    gid_nxt   = pick_idx;
                end
            end
            XFER: begin
                s_ready[grant_id] = !bus.fifo_full;
                if (bus.s_valid[grant_id] && !bus.fifo_full) begin
                    wr_en = 1'b1;
                    if (bus.s_last[grant_id]) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = (grant_id == GID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.s_ready    = s_ready;
    assign bus.fifo_wr_en = wr_en;
    // Always driven from the granted source so no X leaks when wr_en=0.
    assign bus.fifo_wdata = {bus.s_last[grant_id], src_data[grant_id]};
    assign busy           = (state == XFER);

`ifdef FIFO_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (wr_en && bus.s_last[gi] && grant_id == GID_W'(gi))
                cnt <= cnt + 1'b1;
        end
        assign frame_cnt[gi*CNT_W +: CNT_W] = cnt;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin/frame model.
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 32;
`ifdef FIFO_ARB_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*CW-1:0] frame_cnt;
`endif

    int vec = 0;
    int err = 0;

    fifo_arb_if #(.NUM_SRC(N), .WIDTH(W)) bus ();

    fifo_wr_arbiter #(.NUM_SRC(N), .WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Source stimulus state: current beat, frame number, frame length.
    logic [N-1:0] en;
    int  beat [N];
    int  frm  [N];
    int  flen [N];
    bit  rand_len;

    function automatic logic [W-1:0] tag(input int i, input int f, input int b);
        return {8'(i), 8'(f), 16'(b)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.s_valid[i]          = en[i];
            bus.s_data[i*W +: W]    = tag(i, frm[i], beat[i]);
            bus.s_last[i]           = (beat[i] == flen[i] - 1);
        end
    endtask

    // Capture accepted beats before the edge, then move each source on.
    task automatic advance();
        logic [N-1:0] acc;
        acc = bus.s_valid & bus.s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (beat[i] == flen[i] - 1) begin
                    beat[i] = 0;
                    frm[i]++;
                    if (rand_len) flen[i] = $urandom_range(1, 4);
                end else begin
                    beat[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic clear_src();
        en = '0;
        rand_len = 1'b0;
        for (int i = 0; i < N; i++) begin
            beat[i] = 0; frm[i] = 0; flen[i] = 2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.fifo_full = 1'b0;
        bus.fifo_almost_full = 1'b0;
        clear_src();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fifo_full = 1'b0;
        bus.fifo_almost_full = 1'b0;
        clear_src();
        en = '1;
        drive();
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vec++; if (grant_id !== 2'd0) begin err++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        vec++; if (bus.s_ready !== 4'b0) begin err++; $display("FAIL reset_ready got=%b exp=0000", bus.s_ready); end
        vec++; if (bus.fifo_wr_en !== 1'b0) begin err++; $display("FAIL reset_wr_en got=%b exp=0", bus.fifo_wr_en); end
    endtask

    task automatic test_single_src();
        logic [W-1:0] d [4];
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
        do_reset();
        en = 4'b0001;
        bus.s_valid = 4'b0001;
        bus.s_data[W-1:0] = d[0];
        bus.s_last = 4'b0;
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL single_idle busy got=%b exp=0", busy); end
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            bus.s_data[W-1:0] = d[b];
            bus.s_last[0] = (b == 3);
            @(negedge clk);
            vec++; if (bus.fifo_wr_en !== 1'b1 || grant_id !== 2'd0)
                begin err++; $display("FAIL single_wr beat%0d got wr=%b gid=%0d exp wr=1 gid=0", b, bus.fifo_wr_en, grant_id); end
            vec++; if (bus.fifo_wdata !== {(b == 3), d[b]})
                begin err++; $display("FAIL single_wdata beat%0d got=%h exp=%h", b, bus.fifo_wdata, {(b == 3), d[b]}); end
        end
        @(posedge clk); #1;
        bus.s_valid = '0;
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    endtask

    // All sources stream 2-beat frames: idle, beat0, beat1 per frame, rotating 0..3.
    task automatic test_round_robin();
        int k, g;
        do_reset();
        en = '1;
        drive();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            k = c / 3;
            g = k % N;
            vec++; if (bus.fifo_wr_en !== (c % 3 != 0))
                begin err++; $display("FAIL rr_wr_en cyc%0d got=%b exp=%b", c, bus.fifo_wr_en, (c % 3 != 0)); end
            if (c % 3 != 0) begin
                vec++; if (grant_id !== 2'(g) || bus.s_ready !== 4'(1 << g))
                    begin err++; $display("FAIL rr_grant cyc%0d got gid=%0d rdy=%b exp gid=%0d", c, grant_id, bus.s_ready, g); end
                vec++; if (bus.fifo_wdata !== {(c % 3 == 2), tag(g, k / N, c % 3 - 1)})
                    begin err++; $display("FAIL rr_wdata cyc%0d got=%h", c, bus.fifo_wdata); end
            end
            advance();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        en = 4'b0010;
        flen[1] = 6;
        drive();
        @(negedge clk); advance();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            vec++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wdata !== {1'b0, tag(1, 0, b)})
                begin err++; $display("FAIL full_pre beat%0d got wr=%b wdata=%h", b, bus.fifo_wr_en, bus.fifo_wdata); end
            advance();
        end
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec++; if (bus.s_ready[1] !== 1'b0 || bus.fifo_wr_en !== 1'b0 || busy !== 1'b1)
                begin err++; $display("FAIL full_stall cyc%0d got rdy=%b wr=%b busy=%b exp 0 0 1", k, bus.s_ready[1], bus.fifo_wr_en, busy); end
            advance();
        end
        bus.fifo_full = 1'b0;
        @(negedge clk);
        vec++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wdata !== {1'b0, tag(1, 0, 2)})
            begin err++; $display("FAIL full_resume got wr=%b wdata=%h exp wr=1 wdata=%h", bus.fifo_wr_en, bus.fifo_wdata, {1'b0, tag(1, 0, 2)}); end
    endtask

    task automatic test_almost_full();
        do_reset();
        bus.fifo_almost_full = 1'b1;
        en = 4'b0100;
        flen[2] = 4;
        drive();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vec++; if (busy !== 1'b0 || bus.fifo_wr_en !== 1'b0)
                begin err++; $display("FAIL af_hold cyc%0d got busy=%b wr=%b exp 0 0", k, busy, bus.fifo_wr_en); end
            advance();
        end
        bus.fifo_almost_full = 1'b0;
        @(negedge clk); advance();
        bus.fifo_almost_full = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            vec++; if (bus.fifo_wr_en !== 1'b1 || grant_id !== 2'd2 || bus.fifo_wdata !== {(b == 3), tag(2, 0, b)})
                begin err++; $display("FAIL af_midframe beat%0d got wr=%b gid=%0d wdata=%h", b, bus.fifo_wr_en, grant_id, bus.fifo_wdata); end
            advance();
        end
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL af_restart got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        en = 4'b0100;
        flen[2] = 1;
        drive();
        @(negedge clk); advance();
        @(negedge clk); advance();
        en = 4'b1000;
        flen[3] = 4;
        drive();
        @(negedge clk); advance();
        @(negedge clk);
        vec++; if (grant_id !== 2'd3 || bus.fifo_wr_en !== 1'b1)
            begin err++; $display("FAIL rstmid_grant got gid=%0d wr=%b exp gid=3 wr=1", grant_id, bus.fifo_wr_en); end
        advance();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vec++; if (bus.s_ready !== 4'b0 || bus.fifo_wr_en !== 1'b0 || busy !== 1'b0)
            begin err++; $display("FAIL rstmid_outputs got rdy=%b wr=%b busy=%b exp 0", bus.s_ready, bus.fifo_wr_en, busy); end
        @(posedge clk); #1;
        clear_src();
        en = '1;
        drive();
        rst_n = 1'b1;
        @(negedge clk); advance();
        @(negedge clk);
        vec++; if (busy !== 1'b1 || grant_id !== 2'd0)
            begin err++; $display("FAIL rstmid_first_grant got busy=%b gid=%0d exp busy=1 gid=0", busy, grant_id); end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        logic [N*CW-1:0] mask;
        mask = '0;
        mask[2*CW +: CW] = '1;
        do_reset();
        en = 4'b0100;
        flen[2] = 1;
        drive();
        for (int f = 1; f <= 5; f++) begin
            @(negedge clk); advance();
            @(negedge clk); advance();
            vec++; if (frame_cnt[2*CW +: CW] !== CW'(f % 4) || (frame_cnt & ~mask) !== '0)
                begin err++; $display("FAIL stats frame%0d got cnt=%h exp cnt2=%0d", f, frame_cnt, f % 4); end
        end
    endtask
`endif

    // Randomized traffic against a frame-level round-robin model.
    task automatic test_random();
        bit m_busy;
        int m_gid, m_ptr, best, bd, d;
        logic [N-1:0] exp_rdy;
        logic exp_wr;
        do_reset();
        rand_len = 1'b1;
        for (int i = 0; i < N; i++) flen[i] = $urandom_range(1, 4);
        m_busy = 0; m_gid = 0; m_ptr = 0;
        drive();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            exp_rdy = '0;
            if (m_busy && !bus.fifo_full) exp_rdy[m_gid] = 1'b1;
            exp_wr = m_busy && !bus.fifo_full && bus.s_valid[m_gid];
            vec++; if (busy !== m_busy || (m_busy && grant_id !== 2'(m_gid)))
                begin err++; $display("FAIL rnd_owner cyc%0d got busy=%b gid=%0d exp busy=%b gid=%0d", cyc, busy, grant_id, m_busy, m_gid); end
            vec++; if (bus.s_ready !== exp_rdy || bus.fifo_wr_en !== exp_wr)
                begin err++; $display("FAIL rnd_hs cyc%0d got rdy=%b wr=%b exp rdy=%b wr=%b", cyc, bus.s_ready, bus.fifo_wr_en, exp_rdy, exp_wr); end
            if (exp_wr) begin
                vec++; if (bus.fifo_wdata !== {(beat[m_gid] == flen[m_gid] - 1), tag(m_gid, frm[m_gid], beat[m_gid])})
                    begin err++; $display("FAIL rnd_wdata cyc%0d got=%h", cyc, bus.fifo_wdata); end
            end
            if (!m_busy) begin
                if (|bus.s_valid && !bus.fifo_almost_full) begin
                    best = 0; bd = N;
                    for (int i = 0; i < N; i++) begin
                        d = (i - m_ptr + N) % N;
                        if (bus.s_valid[i] && d < bd) begin bd = d; best = i; end
                    end
                    m_gid = best;
                    m_busy = 1;
                end
            end else if (exp_wr && beat[m_gid] == flen[m_gid] - 1) begin
                m_busy = 0;
                m_ptr = (m_gid + 1) % N;
            end
            advance();
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
            bus.fifo_full = ($urandom_range(0, 4) == 0);
            bus.fifo_almost_full = ($urandom_range(0, 3) == 0);
            drive();
        end
    endtask

    initial begin
        test_reset();
        test_single_src();
        test_round_robin();
        test_full_stall();
        test_almost_full();
        test_reset_midframe();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
